// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press/release/click/long/repeat strobes.
// Everything runs on the 1 kHz slow clock, so tick counts are milliseconds.
module button_events #(
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200,
    parameter int unsigned CNT_W        = 11
) (
    input  logic       i_clk_slow,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_btn_stable,
    output logic       o_press_pulse,
    output logic       o_release_pulse,
    output logic       o_click_pulse,
    output logic       o_long_pulse,
    output logic       o_repeat_pulse,
    output logic       o_held,
    output logic [7:0] o_rep_count
);

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [7:0]       RepMax     = 8'hFF;

    typedef enum logic [1:0] {
        StLock,
        StIdle,
        StShort,
        StLong
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_click;
    logic             r_long;
    logic             r_repeat;
    logic             r_held;
    logic [7:0]       r_rep_count;

    always_ff @(posedge i_clk_slow) begin
        if (i_rst) begin
            r_state     <= StLock;
            r_cnt       <= '0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_click     <= 1'b0;
            r_long      <= 1'b0;
            r_repeat    <= 1'b0;
            r_held      <= 1'b0;
            r_rep_count <= '0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;

            if (!i_en) begin
                // Disabling abandons any hold silently; rep_count is left for inspection.
                r_state <= StLock;
                r_cnt   <= '0;
                r_held  <= 1'b0;
            end else begin
                unique case (r_state)
                    StLock: begin
                        // A button held through reset/enable must be released first.
                        if (!i_btn_stable) begin
                            r_state <= StIdle;
                        end
                    end
                    StIdle: begin
                        if (i_btn_stable) begin
                            r_state     <= StShort;
                            r_press     <= 1'b1;
                            r_held      <= 1'b1;
                            r_cnt       <= CntOne;
                            r_rep_count <= '0;
                        end
                    end
                    StShort: begin
                        if (!i_btn_stable) begin
                            r_state   <= StIdle;
                            r_release <= 1'b1;
                            r_click   <= 1'b1;
                            r_held    <= 1'b0;
                            r_cnt     <= '0;
                        end else if (r_cnt == LongLast) begin
                            r_state <= StLong;
                            r_long  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CntOne;
                        end
                    end
                    StLong: begin
                        if (!i_btn_stable) begin
                            r_state   <= StIdle;
                            r_release <= 1'b1;
                            r_held    <= 1'b0;
                            r_cnt     <= '0;
                        end else if (r_cnt == RepeatLast) begin
                            r_repeat <= 1'b1;
                            r_cnt    <= '0;
                            if (r_rep_count != RepMax) begin
                                r_rep_count <= r_rep_count + 8'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CntOne;
                        end
                    end
                    default: begin
                        r_state <= StLock;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_click_pulse   = r_click;
    assign o_long_pulse    = r_long;
    assign o_repeat_pulse  = r_repeat;
    assign o_held          = r_held;
    assign o_rep_count     = r_rep_count;

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Consumer end of the push-button path: takes the debounced level `btn_stable` and turns it into single-cycle event pulses.
- Events produced: press, release, short click, long press, and auto-repeat while held.
- Runs on the 1 kHz `clk_slow` domain, so tick counts equal milliseconds.
- Feeds the control FSMs (menu/counter logic), which must only ever see clean one-cycle strobes.

Parameters:
- LONG_TICKS, 1000, clk_slow cycles of hold before long_pulse; legal range >= 2.
- REPEAT_TICKS, 200, clk_slow cycles between repeat_pulse strobes once long-press is reached; legal range >= 1.
- CNT_W, 11, width of the internal hold counter; must satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS).

Ports:
- clk_slow  in  1  1 kHz system slow clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; 0 forces LOCK and suppresses all events.
- btn_stable  in  1  debounced button level, 1 = pressed; already synchronous to clk_slow.
- press_pulse  out  1  one-cycle strobe on press.
- release_pulse  out  1  one-cycle strobe on release.
- click_pulse  out  1  one-cycle strobe on release before long-press threshold.
- long_pulse  out  1  one-cycle strobe when hold reaches LONG_TICKS.
- repeat_pulse  out  1  periodic one-cycle strobe while held past long-press.
- held  out  1  level, 1 while state is SHORT or LONG.
- rep_count  out  8  number of repeat_pulse strobes in the current hold; saturates at 255.

Behaviour:
- Interface decision: one clock, clk_slow; reset rst is synchronous and active-high.
- Registering: all outputs are registered. Strobes are high for exactly one clk_slow cycle.
- States: LOCK, IDLE, SHORT, LONG.
- Reset (rst=1 at an edge):
  - state <= LOCK, counter <= 0.
  - All pulse outputs <= 0, held <= 0, rep_count <= 0.
  - rst has priority over en and btn_stable.
- en=0 at an edge:
  - state <= LOCK and all pulses <= 0.
  - No release/click is emitted even if a hold was in progress.
  - held <= 0; rep_count keeps its value.
- LOCK:
  - Leaves to IDLE only at an edge with en=1 and btn_stable=0.
  - Effect: a button held through reset or enable never produces press_pulse.
- IDLE:
  - Edge N samples btn_stable=1 -> state <= SHORT, press_pulse <= 1, counter <= 1, rep_count <= 0.
  - press_pulse is visible in the cycle after edge N.
- SHORT, at each edge:
  - btn_stable=0 -> IDLE, release_pulse <= 1, click_pulse <= 1.
  - else if counter == LONG_TICKS-1 -> LONG, long_pulse <= 1, counter <= 0.
  - else counter <= counter + 1.
  - Result: long_pulse follows edge N+LONG_TICKS-1 when the button is held at every edge N..N+LONG_TICKS-1, i.e. it trails press_pulse by exactly LONG_TICKS-1 cycles.
- LONG, at each edge:
  - btn_stable=0 -> IDLE, release_pulse <= 1, no click_pulse.
  - else if counter == REPEAT_TICKS-1 -> repeat_pulse <= 1, counter <= 0, rep_count <= min(rep_count+1, 255).
  - else counter <= counter + 1.
  - Result: first repeat_pulse arrives REPEAT_TICKS cycles after long_pulse, then every REPEAT_TICKS cycles.
  - With REPEAT_TICKS=1, repeat_pulse stays high every cycle; this is legal.
- Simultaneous events:
  - Release sampled on the same edge the threshold would be reached: release wins, no long/repeat strobe.
  - A click is emitted if the state was SHORT at that edge.
- A 1-cycle press (btn_stable high for one edge): press_pulse then, at the next edge, release_pulse + click_pulse in the same cycle.
- Back-to-back press: from IDLE, a new press at the edge right after release is accepted normally.
- held:
  - Goes high in the same cycle as press_pulse.
  - Goes low in the same cycle as release_pulse.
- Counter:
  - Never exceeds max(LONG_TICKS, REPEAT_TICKS)-1.
  - No wrap-around is reachable.

Test Plan (LONG_TICKS=10, REPEAT_TICKS=4):
- Reset hold-through: btn_stable=1 during and 20 cycles after rst -> no strobes, held=0. Then btn 0 for 1 cycle and 1 again -> exactly one press_pulse.
- Short click: press for 5 cycles -> press_pulse once, then release_pulse and click_pulse together 5 cycles later, long_pulse never, held high 5 cycles.
- Long + repeat: press for 25 cycles -> long_pulse 9 cycles after press_pulse, repeat_pulse at +13, +17, +21, +25 relative to press_pulse? No: releases at edge 25, so repeats at +13, +17, +21 only. Then release_pulse without click, rep_count=3.
- Boundary release: btn high exactly 9 edges (release sampled at edge where counter==9) -> click_pulse + release_pulse, no long_pulse.
- Enable drop mid-hold: en=0 during LONG -> all strobes stop, no release_pulse. en=1 with button still pressed -> nothing until button released and re-pressed.
- Saturation: with REPEAT_TICKS=1, hold 300 cycles past long_pulse -> rep_count stops at 255 while repeat_pulse keeps firing.
